// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the oscillator-domain clock/reset manager.
// FSM encodings, loss-counter width and the default timing constants.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int LOSS_W = 16;

  localparam int DEF_N_CH         = 2;
  localparam int DEF_DIV_W        = 8;
  localparam int DEF_PLL_RST_CYC  = 16;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_LOCK_TIMEOUT = 1048576;
  localparam int DEF_STAGE_GAP    = 16;

  // Width of a counter running 0..limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/clock_ctrl_clken_div.sv
// Per-channel clock-enable divider: one-cycle strobe every div cycles, held at zero while hold=1.
// A divisor of 0 behaves as 1, giving a constant-high strobe.
module clken_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

  // NOTE: every variable written in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    last = '0;
    if (div != '0) last = div - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (hold) begin
      cnt    <= '0;
      strobe <= 1'b0;
    end else if (cnt == last) begin
      cnt    <= '0;
      strobe <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Clock/reset manager on the board oscillator: PLL lock supervision with retry, staged channel
// reset release and divided clock enables. Define CLOCK_CTRL_LOSSCNT_EN to add the loss_cnt port.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int                     N_CH         = DEF_N_CH,
  parameter int                     DIV_W        = DEF_DIV_W,
  parameter logic [N_CH*DIV_W-1:0]  DIVS         = {8'd3, 8'd1},
  parameter int                     PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int                     LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int                     LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int                     STAGE_GAP    = DEF_STAGE_GAP
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              locked_in,
  output logic              pll_rst,
  output logic [N_CH-1:0]   rst_out,
  output logic [N_CH-1:0]   clken,
  output logic              ready
`ifdef CLOCK_CTRL_LOSSCNT_EN
  ,
  output logic [LOSS_W-1:0] loss_cnt
`endif
);

  localparam int PLL_W   = cnt_w(PLL_RST_CYC);
  localparam int TO_W    = cnt_w(LOCK_TIMEOUT);
  localparam int STB_W   = cnt_w(LOCK_STABLE);
  localparam int REL_LIM = (N_CH - 1) * STAGE_GAP + 1;
  localparam int REL_W   = cnt_w(REL_LIM);

  localparam logic [PLL_W-1:0] PLL_LAST = PLL_W'(PLL_RST_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_LIM - 1);

  state_t            state;
  logic              lock_meta;
  logic              lock_s;
  logic              lost;
  logic [N_CH-1:0]   hold;
  logic [PLL_W-1:0]  pll_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [STB_W-1:0]  stb_cnt;
  logic [REL_W-1:0]  rel_cnt;

  // locked_in is asynchronous to clk_in; two flops before any decision is taken on it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked_in;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    lost = 1'b0;
    if (!lock_s && (state == STABLE || state == RELEASE || state == RUN)) lost = 1'b1;
  end

  // Dividers are held on the same edge the FSM reasserts the channel resets.
  assign hold = rst_out | {N_CH{lost}};

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= PLLRST;
      pll_rst <= 1'b1;
      rst_out <= '1;
      ready   <= 1'b0;
      pll_cnt <= '0;
      to_cnt  <= '0;
      stb_cnt <= '0;
      rel_cnt <= '0;
    end else if (lost) begin
      // Lock dropped after it was seen: back to waiting without resetting the PLL.
      state   <= WAIT_LOCK;
      rst_out <= '1;
      ready   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      case (state)
        PLLRST: begin
          pll_rst <= 1'b1;
          if (pll_cnt == PLL_LAST) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
            pll_cnt <= '0;
            to_cnt  <= '0;
          end else begin
            pll_cnt <= pll_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state   <= STABLE;
            stb_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state   <= PLLRST;
            pll_rst <= 1'b1;
            pll_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        STABLE: begin
          if (stb_cnt == STB_LAST) begin
            state   <= RELEASE;
            rel_cnt <= '0;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        RELEASE: begin
          for (int i = 0; i < N_CH; i++) begin
            if (rel_cnt == REL_W'(i * STAGE_GAP)) rst_out[i] <= 1'b0;
          end
          if (rel_cnt == REL_LAST) begin
            state <= RUN;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state   <= PLLRST;
          pll_rst <= 1'b1;
          rst_out <= '1;
          ready   <= 1'b0;
          pll_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CLOCK_CTRL_LOSSCNT_EN
  // Saturating count of lock losses seen while fully running.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (lost && state == RUN && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clken_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk_in (clk_in),
      .rst    (rst),
      .hold   (hold[i]),
      .div    (DIVS[i*DIV_W +: DIV_W]),
      .strobe (clken[i])
    );
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with short timing constants; expected values hand-derived per edge.
// Edge numbering restarts at 1 on the first clock edge after each reset release.
module tb_clock_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        locked_in;
  logic        pll_rst;
  logic [1:0]  rst_out;
  logic [1:0]  clken;
  logic        ready;
`ifdef CLOCK_CTRL_LOSSCNT_EN
  logic [15:0] loss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk_in = ~clk_in;

  clock_ctrl #(
    .N_CH         (2),
    .DIV_W        (8),
    .DIVS         (16'h0301),
    .PLL_RST_CYC  (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (64),
    .STAGE_GAP    (3)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .locked_in (locked_in),
    .pll_rst   (pll_rst),
    .rst_out   (rst_out),
    .clken     (clken),
    .ready     (ready)
`ifdef CLOCK_CTRL_LOSSCNT_EN
    ,
    .loss_cnt  (loss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge k.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk_in);
      @(negedge clk_in);
      cyc++;
    end
  endtask

  task automatic do_reset(input logic lock);
    @(negedge clk_in);
    rst       = 1'b1;
    locked_in = lock;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst       = 1'b1;
    locked_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Reset values
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_rst_out", 32'(rst_out), 32'b11);
    check("rst_clken",   32'(clken),   32'b00);
    check("rst_ready",   32'(ready),   32'd0);
`ifdef CLOCK_CTRL_LOSSCNT_EN
    check("rst_loss_cnt", 32'(loss_cnt), 32'd0);
`endif

    // 1: lock present from the start; WAIT_LOCK entered at edge 4
    do_reset(1'b1);
    goto(3);  check("t1_pll_rst_hi",  32'(pll_rst), 32'd1);
    goto(4);  check("t1_pll_rst_lo",  32'(pll_rst), 32'd0);
    goto(13); check("t1_rst_out_e13", 32'(rst_out), 32'b11);
    goto(14); check("t1_rst_out_e14", 32'(rst_out), 32'b10);
              check("t1_clken_e14",   32'(clken),   32'b00);
    goto(15); check("t1_clken_e15",   32'(clken),   32'b01);
    goto(16); check("t1_rst_out_e16", 32'(rst_out), 32'b10);
    goto(17); check("t1_rst_out_e17", 32'(rst_out), 32'b00);
              check("t1_ready_e17",   32'(ready),   32'd0);
    goto(18); check("t1_ready_e18",   32'(ready),   32'd1);

    // 2: clken[0] constant, clken[1] every third cycle from edge 20
    goto(19); check("t2_clken_e19", 32'(clken), 32'b01);
    goto(20); check("t2_clken_e20", 32'(clken), 32'b11);
    goto(21); check("t2_clken_e21", 32'(clken), 32'b01);
    goto(22); check("t2_clken_e22", 32'(clken), 32'b01);
    goto(23); check("t2_clken_e23", 32'(clken), 32'b11);
    goto(26); check("t2_clken_e26", 32'(clken), 32'b11);

    // 5: lock drops after edge 30, seen by the FSM at edge 33
    goto(30); locked_in = 1'b0;
    goto(32); check("t5_ready_e32",   32'(ready),   32'd1);
              check("t5_rst_out_e32", 32'(rst_out), 32'b00);
    goto(33); check("t5_rst_out_e33", 32'(rst_out), 32'b11);
              check("t5_clken_e33",   32'(clken),   32'b00);
              check("t5_ready_e33",   32'(ready),   32'd0);
              check("t5_pll_rst_e33", 32'(pll_rst), 32'd0);
`ifdef CLOCK_CTRL_LOSSCNT_EN
              check("t5_loss_cnt", 32'(loss_cnt), 32'd1);
`endif
    goto(35); locked_in = 1'b1;
    goto(37); check("t5_pll_rst_e37", 32'(pll_rst), 32'd0);
    goto(46); check("t5_rst_out_e46", 32'(rst_out), 32'b11);
    goto(47); check("t5_rst_out_e47", 32'(rst_out), 32'b10);

    // 6: asynchronous reset while in RELEASE
    goto(48); check("t6_rst_out_e48", 32'(rst_out), 32'b10);
    #2 rst = 1'b1;
    #1;
    check("t6_pll_rst", 32'(pll_rst), 32'd1);
    check("t6_rst_out", 32'(rst_out), 32'b11);
    check("t6_clken",   32'(clken),   32'b00);
    check("t6_ready",   32'(ready),   32'd0);
`ifdef CLOCK_CTRL_LOSSCNT_EN
    check("t6_loss_cnt", 32'(loss_cnt), 32'd0);
`endif

    // 3: no lock; 64-cycle WAIT_LOCK then 4-cycle pll_rst pulse, repeated
    do_reset(1'b0);
    goto(4);   check("t3_pll_rst_e4",   32'(pll_rst), 32'd0);
    goto(67);  check("t3_pll_rst_e67",  32'(pll_rst), 32'd0);
    goto(68);  check("t3_pll_rst_e68",  32'(pll_rst), 32'd1);
    goto(71);  check("t3_pll_rst_e71",  32'(pll_rst), 32'd1);
    goto(72);  check("t3_pll_rst_e72",  32'(pll_rst), 32'd0);
    goto(135); check("t3_pll_rst_e135", 32'(pll_rst), 32'd0);
    goto(136); check("t3_pll_rst_e136", 32'(pll_rst), 32'd1);
    goto(140); check("t3_pll_rst_e140", 32'(pll_rst), 32'd0);
    goto(204); check("t3_pll_rst_e204", 32'(pll_rst), 32'd1);
    goto(208); check("t3_pll_rst_e208", 32'(pll_rst), 32'd0);
               check("t3_rst_out",      32'(rst_out), 32'b11);
               check("t3_ready",        32'(ready),   32'd0);

    // 4: one-cycle lock glitch in STABLE restarts the stable count (release moves 14 -> 20)
    do_reset(1'b1);
    goto(7);  locked_in = 1'b0;
    goto(8);  locked_in = 1'b1;
    goto(14); check("t4_rst_out_e14", 32'(rst_out), 32'b11);
    goto(19); check("t4_rst_out_e19", 32'(rst_out), 32'b11);
    goto(20); check("t4_rst_out_e20", 32'(rst_out), 32'b10);
    goto(23); check("t4_rst_out_e23", 32'(rst_out), 32'b00);
    goto(24); check("t4_ready_e24",   32'(ready),   32'd1);
              check("t4_pll_rst_e24", 32'(pll_rst), 32'd0);

`ifdef CLOCK_CTRL_LOSSCNT_EN
    // Saturation: preload near the top, then two more RUN losses
    goto(25);
    force dut.loss_cnt = 16'hFFFE;
    #1 release dut.loss_cnt;
    goto(30); locked_in = 1'b0;
    goto(33); check("sat_loss_first", 32'(loss_cnt), 32'hFFFF);
    goto(35); locked_in = 1'b1;
    goto(51); check("sat_ready_e51", 32'(ready), 32'd1);
    goto(55); locked_in = 1'b0;
    goto(58); check("sat_ready_e58", 32'(ready), 32'd0);
              check("sat_loss_hold", 32'(loss_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
